// File: rtl/stoch_to_bin_pkg.sv
// Shared definitions for the stochastic-to-binary decoder.
// The default window width is also used by the stochastic number generators
// so encoder and decoder windows stay the same length.
package stoch_to_bin_pkg;

    // Default log2 of the window length (also the per-lane result width)
    localparam int STOCH_WIN_W_DEFAULT = 8;

    // Default number of parallel stochastic lanes
    localparam int STOCH_LANES_DEFAULT = 3;

    // Decoder control states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } stoch_state_e;

endpackage : stoch_to_bin_pkg

// File: rtl/stoch_to_bin_lane_cnt.sv
// One decoder lane: counts ones of a stochastic bitstream over a window and
// latches the saturated count into a result register on the window's last
// accepted sample.
module stoch_lane_cnt #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         accept_i,
    input  logic         last_i,
    input  logic         clr_i,
    input  logic         bit_i,
    output logic [W-1:0] res_o
);

    // A full window of ones gives 2^W, which does not fit in W bits; clamp it.
    function automatic logic [W-1:0] sat_cnt(input logic [W:0] cnt);
        logic [W-1:0] r;
        if (cnt[W]) r = {W{1'b1}};
        else        r = cnt[W-1:0];
        return r;
    endfunction

    logic [W:0]   cnt_q, cnt_d;
    logic [W:0]   sum;
    logic [W-1:0] res_q, res_d;

    // Next-state: abort clears the partial count, the last sample publishes it
    always_comb begin
        sum   = cnt_q + {{W{1'b0}}, bit_i};
        cnt_d = cnt_q;
        res_d = res_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            if (last_i) begin
                res_d = sat_cnt(sum);
                cnt_d = '0;
            end else begin
                cnt_d = sum;
            end
        end
    end

    // Count and result registers, both cleared by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule : stoch_lane_cnt

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary decoder: N lanes each count ones over 2^W accepted
// samples; all lane results are presented together with a one-cycle VALID.
// The top owns the IDLE/ACCUM control, the shared window counter, VALID and
// BUSY; per-lane counting lives in stoch_lane_cnt.
module stoch_to_bin
    import stoch_to_bin_pkg::*;
#(
    parameter int N = STOCH_LANES_DEFAULT,
    parameter int W = STOCH_WIN_W_DEFAULT
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           EN,
    input  logic           CLR,
    input  logic [N-1:0]   IN,
    output logic [N*W-1:0] OUT,
    output logic           VALID,
    output logic           BUSY
);

    localparam logic [W-1:0] WIN_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] WIN_LAST = {W{1'b1}};

    stoch_state_e state_q;
    logic [W-1:0] win_q;
    logic         valid_q;
    logic         busy_q;

    logic accept;
    logic last;

    // CLR outranks EN, so an aborting edge never counts as a sample
    assign accept = EN & ~CLR;
    // win_q only reaches its top value inside ACCUM
    assign last   = accept && (state_q == ST_ACCUM) && (win_q == WIN_LAST);

    // Control FSM with window counter and registered VALID/BUSY
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (CLR) begin
                state_q <= ST_IDLE;
                win_q   <= '0;
                busy_q  <= 1'b0;
            end else if (EN) begin
                case (state_q)
                    ST_IDLE: begin
                        // This sample is index 0 of the new window
                        state_q <= ST_ACCUM;
                        busy_q  <= 1'b1;
                        win_q   <= WIN_ONE;
                    end
                    ST_ACCUM: begin
                        // Wraps to 0 after the last sample, so the next
                        // accepted sample starts a new window with no gap
                        win_q   <= win_q + WIN_ONE;
                        valid_q <= last;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        win_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar n = 0; n < N; n++) begin : g_lane
        stoch_lane_cnt #(
            .W(W)
        ) u_lane (
            .CLK      (CLK),
            .RESET    (RESET),
            .accept_i (accept),
            .last_i   (last),
            .clr_i    (CLR),
            .bit_i    (IN[n]),
            .res_o    (OUT[n*W +: W])
        );
    end

    assign VALID = valid_q;
    assign BUSY  = busy_q;

endmodule : stoch_to_bin

// File: tb/tb_stoch_to_bin.sv
// Bench for stoch_to_bin (N=2, W=4). Stimulus feeds a window-level model;
// completed windows are queued and matched by a negedge monitor.
module tb_stoch_to_bin;

    localparam int N   = 2;
    localparam int W   = 4;
    localparam int WIN = 1 << W;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           EN = 1'b0;
    logic           CLR = 1'b0;
    logic [N-1:0]   IN = '0;
    logic [N*W-1:0] OUT;
    logic           VALID;
    logic           BUSY;

    stoch_to_bin #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .CLR   (CLR),
        .IN    (IN),
        .OUT   (OUT),
        .VALID (VALID),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;
    int edges  = 0;

    always @(posedge CLK) edges <= edges + 1;

    typedef struct {
        int             edge_no;
        logic [N*W-1:0] out;
    } exp_t;

    exp_t sb[$];

    // Reference model: the samples of the open window, plus visible outputs
    logic [N-1:0]   win[$];
    logic [N*W-1:0] m_out   = '0;
    logic           m_busy  = 1'b0;
    logic           m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_out   = '0;
        m_busy  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [N-1:0] in);
        logic [N*W-1:0] o;
        int s;
        m_valid = 1'b0;
        if (!RESET) begin
            model_reset();
            return;
        end
        if (clr) begin
            win.delete();
            m_busy = 1'b0;
        end else if (en) begin
            m_busy = 1'b1;
            win.push_back(in);
            if (win.size() == WIN) begin
                o = '0;
                for (int n = 0; n < N; n++) begin
                    s = 0;
                    foreach (win[k]) s += int'(win[k][n]);
                    if (s > WIN - 1) s = WIN - 1;
                    o[n*W +: W] = s[W-1:0];
                end
                m_out   = o;
                m_valid = 1'b1;
                sb.push_back('{edges, o});
                win.delete();
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model
    task automatic step(input logic en, input logic clr, input logic [N-1:0] in);
        EN  = en;
        CLR = clr;
        IN  = in;
        @(posedge CLK);
        #1;
        model_edge(en, clr, in);
    endtask

    function automatic logic [N-1:0] pat(input int i);
        logic [N-1:0] v;
        v[0] = (i % 2) == 0;
        v[1] = (i % 4) == 0;
        return v;
    endfunction

    // Monitor: per-cycle output checks and scoreboard matching on VALID
    always @(negedge CLK) begin
        exp_t e;
        check("busy", 32'(BUSY), 32'(m_busy));
        check("valid", 32'(VALID), 32'(m_valid));
        check("out_hold", 32'(OUT), 32'(m_out));
        if (VALID === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL sb_unexpected_valid: got VALID=1 expected no window (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("sb_edge", 32'(edges), 32'(e.edge_no));
                check("sb_out", 32'(OUT), 32'(e.out));
            end
        end
    end

    initial begin
        // Reset state
        #1 RESET = 1'b0;
        #1;
        check("rst_out", 32'(OUT), 32'd0);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 2'b11);
        RESET = 1'b1;

        // Test 1: constant inputs
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 2'b01);
        check("t1_out", 32'(OUT), 32'h0F);

        // Test 2: periodic inputs, two back-to-back windows
        for (int i = 0; i < 2 * WIN; i++) step(1'b1, 1'b0, pat(i));
        check("t2_out", 32'(OUT), 32'h48);

        // Test 3: EN pause in the middle of a window
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, pat(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, N'($urandom));
        for (int i = 7; i < WIN; i++) step(1'b1, 1'b0, pat(i));
        check("t3_out", 32'(OUT), 32'h48);

        // Test 4: CLR abort after 10 samples, then a fresh window
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, N'($urandom));
        step(1'b1, 1'b1, 2'b11);
        check("t4_busy", 32'(BUSY), 32'd0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, N'($urandom));

        // Test 5: CLR on the final sample of a window
        for (int i = 0; i < WIN - 1; i++) step(1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, '0);

        // Test 6: asynchronous reset mid-window, then all-ones window
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 2'b11);
        #2 RESET = 1'b0;
        model_reset();
        #1;
        check("t6_out", 32'(OUT), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_valid", 32'(VALID), 32'd0);
        step(1'b1, 1'b0, 2'b11);
        RESET = 1'b1;
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 2'b01);
        check("t6_win", 32'(OUT), 32'h0F);

        // Random traffic with sparse pauses and aborts
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0, N'($urandom));

        @(negedge CLK);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_stoch_to_bin
